// File: rtl/xor_stream_dec.sv
// xor_stream_dec
// Receive-side descrambler for the 16-bit XOR link. Each accepted ciphertext
// word is XORed with a 16-bit Galois LFSR keystream (x^16+x^14+x^13+x^11+1)
// and presented through a one-word output register. Because XOR is its own
// inverse, the same block with the same seed also works as the scrambler.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   seed_load   one-cycle pulse loading seed_in into the keystream
//   seed_in     seed value (zero is replaced by SEED_DEFAULT)
//   in_valid    ciphertext word present on in_data
//   in_ready    block accepts in_data this cycle
//   in_data     ciphertext word
//   out_valid   plaintext word present on out_data
//   out_ready   consumer accepts out_data this cycle
//   out_data    plaintext word
//   word_count  delivered-word counter (only when XOR_DEC_COUNT_EN is defined)
//
// Build option: define XOR_DEC_COUNT_EN to add the word_count register/port.

module xor_stream_dec #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef XOR_DEC_COUNT_EN
    output logic [15:0] out_data,
    output logic [15:0] word_count
`else
    output logic [15:0] out_data
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        accept;
    logic        deliver;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // A seed load in flight blocks acceptance so the seed always wins.
    assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    // Keystream advances only on accepted words; a stalled output holds
    // both out_data and the LFSR because accept is forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_DEFAULT;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (seed_load) begin
            state     <= RUN;
            lfsr      <= (seed_in == 16'h0000) ? SEED_DEFAULT : seed_in;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= in_data ^ lfsr;
            out_valid <= 1'b1;
            lfsr      <= lfsr_next;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

`ifdef XOR_DEC_COUNT_EN
    // Counts words handed to the consumer; cleared by a new seed and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= 16'h0000;
        end else if (seed_load) begin
            word_count <= 16'h0000;
        end else if (deliver) begin
            word_count <= word_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_xor_stream_dec.sv
// Directed self-checking bench for xor_stream_dec. Expected values are
// hand-computed from the LFSR polynomial and the default seed 16'hACE1.
// word_count checks are present only when XOR_DEC_COUNT_EN is defined.

module tb_xor_stream_dec;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef XOR_DEC_COUNT_EN
    logic [15:0] word_count;
`endif

    int assertions_evaluated = 0;
    int failures = 0;

    xor_stream_dec dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef XOR_DEC_COUNT_EN
        .out_data  (out_data),
        .word_count(word_count)
`else
        .out_data  (out_data)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        assertions_evaluated++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Pulse seed_load for one cycle with the given seed.
    task automatic loadSeed(input logic [15:0] seed);
        seed_in   = seed;
        seed_load = 1'b1;
        applyStimulus();
        seed_load = 1'b0;
        #1;
    endtask

    // Main directed sequence.
    initial begin
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'h0001;
        exp_seq[1] = 16'hB400;
        exp_seq[2] = 16'h5A00;

        rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0000;
        in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("reset out_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("reset out_data", out_data, 16'h0000);
        checkOutput("reset in_ready", {15'd0, in_ready}, 16'h0000);
`ifdef XOR_DEC_COUNT_EN
        checkOutput("reset word_count", word_count, 16'h0000);
`endif

        // Unseeded: offered words are never accepted.
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("idle in_ready", {15'd0, in_ready}, 16'h0000);
            checkOutput("idle out_valid", {15'd0, out_valid}, 16'h0000);
        end
        in_valid = 1'b0;

        // Seed 1, three zero words back-to-back: raw keystream appears.
        seed_in = 16'h0001; seed_load = 1'b1; #1;
        checkOutput("in_ready during seed_load", {15'd0, in_ready}, 16'h0000);
        applyStimulus();
        seed_load = 1'b0; in_valid = 1'b1; in_data = 16'h0000; #1;
        checkOutput("in_ready after seed", {15'd0, in_ready}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (i == 2) in_valid = 1'b0;
            checkOutput("keystream out_valid", {15'd0, out_valid}, 16'h0001);
            checkOutput("keystream out_data", out_data, exp_seq[i]);
        end
        applyStimulus();
        checkOutput("drain out_valid", {15'd0, out_valid}, 16'h0000);
`ifdef XOR_DEC_COUNT_EN
        checkOutput("count after 3", word_count, 16'h0003);
`endif

        // Zero seed is replaced by the default seed.
        loadSeed(16'h0000);
        checkOutput("zero seed out_valid", {15'd0, out_valid}, 16'h0000);
`ifdef XOR_DEC_COUNT_EN
        checkOutput("zero seed count clr", word_count, 16'h0000);
`endif
        in_valid = 1'b1; in_data = 16'hFFFF;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("default seed data", out_data, 16'h531E);
        applyStimulus();

        // Backpressure: word held, keystream frozen until consumer accepts.
        loadSeed(16'h0001);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        applyStimulus();
        in_data = 16'h5678; #1;
        checkOutput("stall first data", out_data, 16'h1235);
        checkOutput("stall in_ready", {15'd0, in_ready}, 16'h0000);
        applyStimulus();
        checkOutput("stall hold data", out_data, 16'h1235);
        checkOutput("stall hold valid", {15'd0, out_valid}, 16'h0001);
        out_ready = 1'b1; #1;
        checkOutput("release in_ready", {15'd0, in_ready}, 16'h0001);
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("second word data", out_data, 16'hE278);
        applyStimulus();
        checkOutput("second drain valid", {15'd0, out_valid}, 16'h0000);

        // Seed collides with a word while output is pending: seed wins.
        loadSeed(16'h0001);
        in_valid = 1'b1; in_data = 16'h0000;
        applyStimulus();
        applyStimulus();
        checkOutput("pre-collide data", out_data, 16'hB400);
        seed_in = 16'h0002; seed_load = 1'b1; out_ready = 1'b0;
        in_data = 16'h1111; #1;
        checkOutput("collide in_ready", {15'd0, in_ready}, 16'h0000);
        applyStimulus();
        seed_load = 1'b0;
        checkOutput("collide flush", {15'd0, out_valid}, 16'h0000);
`ifdef XOR_DEC_COUNT_EN
        checkOutput("collide count", word_count, 16'h0000);
`endif
        out_ready = 1'b1;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("new seed data", out_data, 16'h1113);
        applyStimulus();

`ifdef XOR_DEC_COUNT_EN
        // Counter wrap: 65535 deliveries then one more.
        loadSeed(16'h0001);
        in_valid = 1'b1;
        repeat (65535) applyStimulus();
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("count at FFFF", word_count, 16'hFFFF);
        in_valid = 1'b1;
        applyStimulus();
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("count wrap", word_count, 16'h0000);
`endif

        // Reset mid-stream drops the pending word.
        loadSeed(16'h0001);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0F0F;
        applyStimulus();
        checkOutput("pre-reset valid", {15'd0, out_valid}, 16'h0001);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; in_valid = 1'b0; #1;
        checkOutput("mid reset valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("mid reset data", out_data, 16'h0000);
        checkOutput("mid reset in_ready", {15'd0, in_ready}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule

// File: doc/xor_stream_dec.md
# xor_stream_dec

Receive-side descrambler for the 16-bit XOR link. Recovers plaintext words by XORing each accepted ciphertext word with a 16-bit Galois LFSR keystream that is seeded identically at both ends. Sits between the link input buffer and the consumer, with valid/ready handshakes on both sides and a one-word output register. Because XOR is its own inverse, the same block run with the same seed regenerates the ciphertext from plaintext, so it can also serve as the transmit-side scrambler in loopback tests.

## Interface
- SEED_DEFAULT, 16'hACE1, LFSR value used when a zero seed is loaded and after reset
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- seed_load  input  1  one-cycle pulse that loads the keystream seed
- seed_in  input  16  seed value, sampled when seed_load=1
- in_valid  input  1  ciphertext word present on in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  16  ciphertext word
- out_valid  output  1  plaintext word present on out_data
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  16  plaintext word
- word_count  output  16  delivered-word counter; present only with XOR_DEC_COUNT_EN

## Operation
- FSM has two states:
  - IDLE: unseeded; in_ready=0.
  - RUN: keystream active.
- State transitions:
  - Reset moves to IDLE.
  - seed_load=1 in either state moves to RUN.
  - There is no other exit from RUN except rst.
- LFSR step: lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000), i.e. polynomial x^16+x^14+x^13+x^11+1.
- Seed load:
  - lfsr <= (seed_in == 0) ? SEED_DEFAULT : seed_in. A zero seed would lock the LFSR, so it is replaced.
  - out_valid <= 0, flushing any pending word.
  - word_count <= 0.
- in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
- Accept when in_valid && in_ready:
  - out_data <= in_data ^ lfsr.
  - out_valid <= 1.
  - lfsr <= lfsr_next.
- The keystream advances exactly once per accepted word, never on idle or stalled cycles.
- Output side:
  - Word leaves on out_valid && out_ready.
  - If no new word is accepted in that cycle, out_valid <= 0.
  - While out_valid && !out_ready, out_data and lfsr hold.
- Simultaneous seed_load and in_valid: the seed wins and the word is not accepted, because in_ready=0.
- word_count increments on each out_valid && out_ready and wraps from 16'hFFFF to 0.
- Reset mid-stream: all state returns to reset values on the next edge. The pending output word is lost.

## Timing
- Reset values:
  - state=IDLE, lfsr=SEED_DEFAULT.
  - out_valid=0, out_data=16'h0000.
  - in_ready=0, word_count=0.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Back-to-back accept and deliver happen in the same cycle.
- After a seed_load pulse in cycle N, in_ready can first be 1 in cycle N+1.
- in_ready depends combinationally on out_ready, state, and seed_load. It does not depend on in_valid.

## Configuration
- XOR_DEC_COUNT_EN:
  - Defined: the 16-bit word_count register and port exist, with the behaviour described above.
  - Undefined: the port and register are omitted. All other behaviour is identical.

## Test plan
- Reset, then in_valid=1 with no seed_load -> in_ready=0 and out_valid=0 indefinitely.
- seed_in=16'h0001 pulse, then three in_data=16'h0000 words with out_ready=1 -> out_data sequence 16'h0001, 16'hB400, 16'h5A00 on consecutive cycles. word_count reaches 3.
- seed_in=16'h0000 pulse, then in_data=16'hFFFF -> out_data=16'h531E (16'hFFFF ^ 16'hACE1).
- seed 16'h0001, out_ready=0, words 16'h1234 and 16'h5678 offered -> first word accepted and out_data=16'h1235 held, in_ready=0. After out_ready=1 for one cycle, 16'h5678 ^ 16'hB400 = 16'hE278 appears next.
- seed_load asserted in the same cycle as in_valid while out_valid=1 -> word not accepted, out_valid=0 next cycle, word_count=0, and the next word uses the new seed.
- Force word_count to 16'hFFFF via 65535 deliveries, then deliver one more -> word_count=16'h0000.
